// File: rtl/sdctlxbar_if.sv
// Control-signal bundle between NC disk controllers, the crossbar and NS
// storage devices. Controller c occupies slice c of each c_* vector and
// device d occupies slice d of each s_* vector.
interface sdctlxbar_if #(
  parameter int NC   = 2,
  parameter int NS   = 4,
  parameter int SELW = 3
);
  // controller side
  logic [NC*SELW-1:0] c_sdsel;
  logic [NC-1:0]      c_read;
  logic [NC-1:0]      c_write;
  logic [NC*22-1:0]   c_ba;
  logic [NC*32-1:0]   c_lba;
  logic [NC*16-1:0]   c_wc;
  logic [NC-1:0]      c_iba;
  logic [NC-1:0]      c_q22;
  logic [NC-1:0]      c_devrdy;
  logic [NC-1:0]      c_cmdrdy;
  logic [NC-1:0]      c_word_st;
  logic [NC-1:0]      c_nxm;
  logic [NC-1:0]      c_crcerr;
  logic [NC-1:0]      c_timeout;
  // device side
  logic [NS-1:0]      s_read;
  logic [NS-1:0]      s_write;
  logic [NS*22-1:0]   s_ba;
  logic [NS*32-1:0]   s_lba;
  logic [NS*16-1:0]   s_wc;
  logic [NS-1:0]      s_iba;
  logic [NS-1:0]      s_q22;
  logic [NS-1:0]      s_devrdy;
  logic [NS-1:0]      s_cmdrdy;
  logic [NS-1:0]      s_word_st;
  logic [NS-1:0]      s_nxm;
  logic [NS-1:0]      s_crcerr;

  // environment view: controllers and devices drive their inputs
  modport master (
    output c_sdsel, c_read, c_write, c_ba, c_lba, c_wc, c_iba, c_q22,
    output s_devrdy, s_cmdrdy, s_word_st, s_nxm, s_crcerr,
    input  c_devrdy, c_cmdrdy, c_word_st, c_nxm, c_crcerr, c_timeout,
    input  s_read, s_write, s_ba, s_lba, s_wc, s_iba, s_q22
  );

  // crossbar view
  modport slave (
    input  c_sdsel, c_read, c_write, c_ba, c_lba, c_wc, c_iba, c_q22,
    input  s_devrdy, s_cmdrdy, s_word_st, s_nxm, s_crcerr,
    output c_devrdy, c_cmdrdy, c_word_st, c_nxm, c_crcerr, c_timeout,
    output s_read, s_write, s_ba, s_lba, s_wc, s_iba, s_q22
  );
endinterface

// File: rtl/sdctlxbar.sv
// Disk-controller to storage-device control crossbar. Every device owns an
// IDLE/ARM/BUSY owner FSM with its own round-robin pointer and start
// watchdog, so transfers to different devices proceed concurrently.
module sdctlxbar #(
  parameter int NC       = 2,
  parameter int NS       = 4,
  parameter int SELW     = 3,
  parameter int START_TO = 1023
) (
  input logic        clk,
  input logic        reset,
  sdctlxbar_if.slave bus
);

  localparam int OW = (NC > 1) ? $clog2(NC) : 1;
  localparam int DW = (NS > 1) ? $clog2(NS) : 1;
  localparam int TW = $clog2(START_TO + 1);
  localparam int CW = (TW > 10) ? TW : 10;
  localparam logic [CW-1:0] TO_LAST = CW'(START_TO - 1);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_BUSY = 2'd2
  } dev_state_t;

  dev_state_t    state    [NS];
  logic [OW-1:0] owner    [NS];
  logic [OW-1:0] rr       [NS];
  logic [CW-1:0] wd_cnt   [NS];
  logic [NC-1:0] timeout_q;

  logic [DW-1:0] csel      [NC];
  logic [NC-1:0] owns_dev;
  logic [NC-1:0] req       [NS];
  logic [NS-1:0] grant_any;
  logic [OW-1:0] grant_idx [NS];
  logic [OW-1:0] rr_next   [NS];
  logic [NS-1:0] wd_expire;
  logic [NC-1:0] timeout_next;

  // Out-of-range selects fold onto the last device.
  function automatic logic [DW-1:0] dev_of(input logic [SELW-1:0] sel);
    logic [DW-1:0] d;
    if (int'(sel) >= NS) d = DW'(NS - 1);
    else                 d = DW'(sel);
    return d;
  endfunction

  // Request decode, per-device round-robin pick and watchdog expiry.
  always_comb begin
    int idx;
    int sum;
    idx          = 0;
    sum          = 0;
    owns_dev     = '0;
    timeout_next = '0;
    for (int c = 0; c < NC; c++) begin
      csel[c] = dev_of(bus.c_sdsel[c*SELW +: SELW]);
    end
    // a controller holding a device in ARM/BUSY may not request another
    for (int d = 0; d < NS; d++) begin
      for (int c = 0; c < NC; c++) begin
        owns_dev[c] = owns_dev[c] | ((state[d] != ST_IDLE) && (owner[d] == OW'(c)));
      end
    end
    for (int d = 0; d < NS; d++) begin
      grant_any[d] = 1'b0;
      grant_idx[d] = rr[d];
      wd_expire[d] = (state[d] == ST_ARM) && bus.s_cmdrdy[d] && (wd_cnt[d] == TO_LAST);
      for (int c = 0; c < NC; c++) begin
        req[d][c] = (bus.c_read[c] | bus.c_write[c]) & (csel[c] == DW'(d)) & ~owns_dev[c];
      end
      // first requester at or after rr, searching upward mod NC
      for (int i = 0; i < NC; i++) begin
        sum = int'(rr[d]) + i;
        idx = (sum >= NC) ? (sum - NC) : sum;
        if (!grant_any[d] && req[d][idx]) begin
          grant_any[d] = 1'b1;
          grant_idx[d] = OW'(idx);
        end else begin
          grant_any[d] = grant_any[d];
        end
      end
      rr_next[d] = (int'(grant_idx[d]) == (NC - 1)) ? OW'(0) : (grant_idx[d] + OW'(1));
      if (wd_expire[d]) begin
        timeout_next[owner[d]] = 1'b1;
      end else begin
        timeout_next = timeout_next;
      end
    end
  end

  // Per-device owner FSMs, round-robin pointers, watchdogs and timeout pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int d = 0; d < NS; d++) begin
        state[d]  <= ST_IDLE;
        owner[d]  <= '0;
        rr[d]     <= '0;
        wd_cnt[d] <= '0;
      end
      timeout_q <= '0;
    end else begin
      timeout_q <= timeout_next;
      for (int d = 0; d < NS; d++) begin
        case (state[d])
          ST_IDLE: begin
            if (grant_any[d]) begin
              state[d]  <= ST_ARM;
              owner[d]  <= grant_idx[d];
              rr[d]     <= rr_next[d];
              wd_cnt[d] <= '0;
            end else begin
              state[d]  <= ST_IDLE;
            end
          end
          ST_ARM: begin
            if (!bus.s_cmdrdy[d])   state[d] <= ST_BUSY;
            else if (wd_expire[d])  state[d] <= ST_IDLE;
            else                    state[d] <= ST_ARM;
            wd_cnt[d] <= (wd_cnt[d] == CNT_MAX) ? wd_cnt[d] : (wd_cnt[d] + CW'(1));
          end
          ST_BUSY: begin
            if (bus.s_cmdrdy[d]) state[d] <= ST_IDLE;
            else                 state[d] <= ST_BUSY;
          end
          default: begin
            state[d] <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Device-side routing: parameters always follow the (last) owner, commands
  // only while the device is held.
  always_comb begin
    logic active;
    active      = 1'b0;
    bus.s_read  = '0;
    bus.s_write = '0;
    bus.s_ba    = '0;
    bus.s_lba   = '0;
    bus.s_wc    = '0;
    bus.s_iba   = '0;
    bus.s_q22   = '0;
    for (int d = 0; d < NS; d++) begin
      active               = (state[d] != ST_IDLE);
      bus.s_read[d]        = active & bus.c_read[owner[d]];
      bus.s_write[d]       = active & bus.c_write[owner[d]];
      bus.s_ba[d*22 +: 22] = bus.c_ba[int'(owner[d])*22 +: 22];
      bus.s_lba[d*32 +: 32] = bus.c_lba[int'(owner[d])*32 +: 32];
      bus.s_wc[d*16 +: 16] = bus.c_wc[int'(owner[d])*16 +: 16];
      bus.s_iba[d]         = bus.c_iba[owner[d]];
      bus.s_q22[d]         = bus.c_q22[owner[d]];
    end
  end

  // Controller-side status: gated to the owner, cmdrdy hidden from non-owners.
  always_comb begin
    logic hit;
    hit           = 1'b0;
    bus.c_devrdy  = '0;
    bus.c_cmdrdy  = '0;
    bus.c_word_st = '0;
    bus.c_nxm     = '0;
    bus.c_crcerr  = '0;
    for (int c = 0; c < NC; c++) begin
      bus.c_devrdy[c] = bus.s_devrdy[csel[c]];
      if ((state[csel[c]] == ST_IDLE) || (owner[csel[c]] == OW'(c))) begin
        bus.c_cmdrdy[c] = bus.s_cmdrdy[csel[c]];
      end else begin
        bus.c_cmdrdy[c] = 1'b0;
      end
      for (int d = 0; d < NS; d++) begin
        hit              = (state[d] != ST_IDLE) && (owner[d] == OW'(c));
        bus.c_word_st[c] = bus.c_word_st[c] | (hit & bus.s_word_st[d]);
        bus.c_nxm[c]     = bus.c_nxm[c]     | (hit & bus.s_nxm[d]);
        bus.c_crcerr[c]  = bus.c_crcerr[c]  | (hit & bus.s_crcerr[d]);
      end
    end
  end

  assign bus.c_timeout = timeout_q;

endmodule

// File: tb/tb_sdctlxbar.sv
// Self-checking bench for sdctlxbar: directed scenarios plus a randomized run
// checked against a transaction-level reference model of device ownership.
module tb_sdctlxbar;
  localparam int NC       = 2;
  localparam int NS       = 4;
  localparam int SELW     = 3;
  localparam int START_TO = 15;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  // reference model: holder = -1 when free, else the controller holding it
  int            holder     [NS];
  int            last_owner [NS];
  int            rr_m       [NS];
  int            age        [NS];
  bit            accepted   [NS];
  logic [NC-1:0] to_pulse_m;

  sdctlxbar_if #(.NC(NC), .NS(NS), .SELW(SELW)) bus ();

  sdctlxbar #(.NC(NC), .NS(NS), .SELW(SELW), .START_TO(START_TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int tb_dev(input int sel);
    return (sel >= NS) ? (NS - 1) : sel;
  endfunction

  // advance the model by one clock edge using the inputs sampled at that edge
  task automatic model_update();
    bit            owns [NC];
    logic [NC-1:0] pulse;
    int            best, bestkey, key, dd;
    if (reset) begin
      for (int d = 0; d < NS; d++) begin
        holder[d] = -1; last_owner[d] = 0; rr_m[d] = 0; age[d] = 0; accepted[d] = 1'b0;
      end
      to_pulse_m = '0;
    end else begin
      for (int c = 0; c < NC; c++) owns[c] = 1'b0;
      for (int d = 0; d < NS; d++) if (holder[d] >= 0) owns[holder[d]] = 1'b1;
      pulse = '0;
      for (int d = 0; d < NS; d++) begin
        if (holder[d] < 0) begin
          best = -1; bestkey = NC;
          for (int c = 0; c < NC; c++) begin
            dd = tb_dev(int'(bus.c_sdsel[c*SELW +: SELW]));
            if ((bus.c_read[c] || bus.c_write[c]) && dd == d && !owns[c]) begin
              key = (c - rr_m[d] + NC) % NC;
              if (key < bestkey) begin bestkey = key; best = c; end
            end
          end
          if (best >= 0) begin
            holder[d] = best; last_owner[d] = best; rr_m[d] = (best + 1) % NC;
            accepted[d] = 1'b0; age[d] = 0;
          end
        end else if (!accepted[d]) begin
          if (!bus.s_cmdrdy[d]) accepted[d] = 1'b1;
          else if (age[d] + 1 == START_TO) begin pulse[holder[d]] = 1'b1; holder[d] = -1; end
          else age[d] = age[d] + 1;
        end else if (bus.s_cmdrdy[d]) begin
          holder[d] = -1;
        end
      end
      to_pulse_m = pulse;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic clear_inputs();
    bus.c_sdsel = '0; bus.c_read = '0; bus.c_write = '0;
    bus.c_ba = '0; bus.c_lba = '0; bus.c_wc = '0; bus.c_iba = '0; bus.c_q22 = '0;
    bus.s_devrdy = '0; bus.s_cmdrdy = '1; bus.s_word_st = '0; bus.s_nxm = '0; bus.s_crcerr = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [21:0] ba0;
    reset = 1'b1;
    clear_inputs();
    bus.c_read = '1; bus.c_write = '1;
    bus.s_word_st = '1; bus.s_nxm = '1; bus.s_crcerr = '1;
    for (int c = 0; c < NC; c++) bus.c_ba[c*22 +: 22] = 22'($urandom());
    ba0 = bus.c_ba[21:0];
    tick();
    n_vec++;
    if ({bus.s_read, bus.s_write} !== 8'h00) begin
      n_err++; $display("FAIL rst_cmds got=%h exp=00", {bus.s_read, bus.s_write});
    end
    n_vec++;
    if ({bus.c_word_st, bus.c_nxm, bus.c_crcerr, bus.c_timeout} !== 8'h00) begin
      n_err++; $display("FAIL rst_status got=%h exp=00", {bus.c_word_st, bus.c_nxm, bus.c_crcerr, bus.c_timeout});
    end
    n_vec++;
    if (bus.s_ba[3*22 +: 22] !== ba0) begin
      n_err++; $display("FAIL rst_owner0_ba got=%h exp=%h", bus.s_ba[3*22 +: 22], ba0);
    end
    tick();
    reset = 1'b0;
    clear_inputs();
  endtask

  task automatic test_single_read();
    logic [2:0] st;
    do_reset();
    bus.c_sdsel[0 +: SELW]    = 3'd2;
    bus.c_sdsel[SELW +: SELW] = 3'd2;
    bus.c_read = 2'b01;
    tick();
    n_vec++;
    if ({bus.s_read, bus.s_write} !== {4'b0100, 4'b0000}) begin
      n_err++; $display("FAIL t1_grant got=%h exp=40", {bus.s_read, bus.s_write});
    end
    n_vec++;
    if (bus.c_cmdrdy !== 2'b01) begin
      n_err++; $display("FAIL t1_loser_cmdrdy got=%b exp=01", bus.c_cmdrdy);
    end
    tick(); tick();
    bus.s_cmdrdy[2] = 1'b0;
    #1;
    n_vec++;
    if (bus.c_cmdrdy[0] !== 1'b0) begin
      n_err++; $display("FAIL t1_cmdrdy_low got=%b exp=0", bus.c_cmdrdy[0]);
    end
    tick();
    bus.c_read[0] = 1'b0;
    for (int k = 0; k < 16; k++) begin
      st = 3'($urandom());
      {bus.s_word_st[2], bus.s_nxm[2], bus.s_crcerr[2]} = st;
      bus.s_word_st[1] = 1'b1;
      #1;
      n_vec++;
      if ({bus.c_word_st, bus.c_nxm, bus.c_crcerr} !== {1'b0, st[2], 1'b0, st[1], 1'b0, st[0]}) begin
        n_err++; $display("FAIL t1_busy_status k=%0d got=%b exp=%b", k,
          {bus.c_word_st, bus.c_nxm, bus.c_crcerr}, {1'b0, st[2], 1'b0, st[1], 1'b0, st[0]});
      end
      tick();
    end
    bus.s_word_st[2] = 1'b1;
    bus.s_cmdrdy[2]  = 1'b1;
    #1;
    n_vec++;
    if (bus.c_word_st !== 2'b01) begin
      n_err++; $display("FAIL t1_busy_until_edge got=%b exp=01", bus.c_word_st);
    end
    tick();
    n_vec++;
    if ({bus.c_word_st, bus.c_cmdrdy, bus.s_read} !== {2'b00, 2'b11, 4'b0000}) begin
      n_err++; $display("FAIL t1_idle_after_rise got=%b exp=00110000", {bus.c_word_st, bus.c_cmdrdy, bus.s_read});
    end
  endtask

  task automatic test_contention();
    logic [21:0] ba0, ba1;
    do_reset();
    ba0 = 22'h0A5A5A; ba1 = 22'h15A5A5;
    bus.c_ba = {ba1, ba0};
    bus.c_sdsel[0 +: SELW]    = 3'd1;
    bus.c_sdsel[SELW +: SELW] = 3'd1;
    bus.c_write = 2'b11;
    tick();
    n_vec++;
    if ({bus.s_write, bus.c_cmdrdy, bus.s_ba[22 +: 22]} !== {4'b0010, 2'b01, ba0}) begin
      n_err++; $display("FAIL t2_first_tie got=%h exp=%h", {bus.s_write, bus.c_cmdrdy, bus.s_ba[22 +: 22]}, {4'b0010, 2'b01, ba0});
    end
    bus.s_cmdrdy[1] = 1'b0;
    tick();
    bus.c_write[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_vec++;
      if ({bus.c_cmdrdy, bus.s_write[1]} !== 3'b000) begin
        n_err++; $display("FAIL t2_loser_wait k=%0d got=%b exp=000", k, {bus.c_cmdrdy, bus.s_write[1]});
      end
    end
    // c0 comes back with a new command just as the device finishes
    bus.s_cmdrdy[1] = 1'b1;
    bus.c_write[0]  = 1'b1;
    tick();
    n_vec++;
    if ({bus.s_write, bus.c_cmdrdy} !== {4'b0000, 2'b11}) begin
      n_err++; $display("FAIL t2_idle_gap got=%b exp=000011", {bus.s_write, bus.c_cmdrdy});
    end
    tick();
    n_vec++;
    if ({bus.s_write[1], bus.c_cmdrdy, bus.s_ba[22 +: 22]} !== {1'b1, 2'b10, ba1}) begin
      n_err++; $display("FAIL t2_second_tie_c1 got=%h exp=%h", {bus.s_write[1], bus.c_cmdrdy, bus.s_ba[22 +: 22]}, {1'b1, 2'b10, ba1});
    end
  endtask

  task automatic test_concurrent();
    logic [21:0] ba0, ba1;
    logic [31:0] lba1;
    logic [15:0] wc0;
    do_reset();
    ba0 = 22'($urandom()); ba1 = 22'($urandom()); lba1 = $urandom(); wc0 = 16'($urandom());
    bus.c_ba = {ba1, ba0}; bus.c_lba[63:32] = lba1; bus.c_wc[15:0] = wc0;
    bus.c_sdsel[0 +: SELW]    = 3'd0;
    bus.c_sdsel[SELW +: SELW] = 3'd3;
    bus.c_read = 2'b11;
    tick();
    n_vec++;
    if (bus.s_read !== 4'b1001) begin
      n_err++; $display("FAIL t3_both_granted got=%b exp=1001", bus.s_read);
    end
    n_vec++;
    if ({bus.s_ba[0 +: 22], bus.s_ba[66 +: 22], bus.s_lba[96 +: 32], bus.s_wc[0 +: 16]} !== {ba0, ba1, lba1, wc0}) begin
      n_err++; $display("FAIL t3_datapath got=%h exp=%h",
        {bus.s_ba[0 +: 22], bus.s_ba[66 +: 22], bus.s_lba[96 +: 32], bus.s_wc[0 +: 16]}, {ba0, ba1, lba1, wc0});
    end
  endtask

  task automatic test_sel_clamp();
    do_reset();
    bus.c_sdsel[SELW +: SELW] = 3'd6;
    bus.s_devrdy = 4'b1000;
    #1;
    n_vec++;
    if (bus.c_devrdy[1] !== 1'b1) begin
      n_err++; $display("FAIL t4_devrdy_hi got=%b exp=1", bus.c_devrdy[1]);
    end
    bus.s_devrdy = 4'b0111;
    #1;
    n_vec++;
    if (bus.c_devrdy[1] !== 1'b0) begin
      n_err++; $display("FAIL t4_devrdy_lo got=%b exp=0", bus.c_devrdy[1]);
    end
    bus.c_read = 2'b10;
    tick();
    n_vec++;
    if (bus.s_read !== 4'b1000) begin
      n_err++; $display("FAIL t4_clamped_grant got=%b exp=1000", bus.s_read);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    bus.c_sdsel[0 +: SELW] = 3'd1;
    bus.c_read = 2'b01;
    tick();
    for (int k = 1; k < START_TO; k++) begin
      tick();
      n_vec++;
      if ({bus.c_timeout, bus.s_read} !== {2'b00, 4'b0010}) begin
        n_err++; $display("FAIL t5_armed k=%0d got=%b exp=000010", k, {bus.c_timeout, bus.s_read});
      end
    end
    tick();
    n_vec++;
    if ({bus.c_timeout, bus.s_read} !== {2'b01, 4'b0000}) begin
      n_err++; $display("FAIL t5_pulse got=%b exp=010000", {bus.c_timeout, bus.s_read});
    end
    bus.c_read = 2'b00;
    tick();
    n_vec++;
    if (bus.c_timeout !== 2'b00) begin
      n_err++; $display("FAIL t5_pulse_width got=%b exp=00", bus.c_timeout);
    end
  endtask

  task automatic test_reset_mid();
    logic [21:0] ba0, ba1;
    do_reset();
    ba0 = 22'h012345; ba1 = 22'h2ABCDE;
    bus.c_ba = {ba1, ba0};
    bus.c_sdsel[0 +: SELW]    = 3'd2;
    bus.c_sdsel[SELW +: SELW] = 3'd2;
    bus.c_read = 2'b01;
    tick();
    bus.s_cmdrdy[2] = 1'b0;
    tick();
    bus.s_word_st[2] = 1'b1;
    reset = 1'b1;
    tick();
    n_vec++;
    if ({bus.s_read, bus.s_write, bus.c_word_st, bus.c_timeout} !== 12'h000) begin
      n_err++; $display("FAIL t6_reset_clear got=%h exp=000", {bus.s_read, bus.s_write, bus.c_word_st, bus.c_timeout});
    end
    reset = 1'b0;
    bus.s_cmdrdy[2] = 1'b1;
    bus.c_read = 2'b11;
    tick();
    n_vec++;
    if ({bus.s_read[2], bus.c_cmdrdy, bus.s_ba[44 +: 22]} !== {1'b1, 2'b01, ba0}) begin
      n_err++; $display("FAIL t6_regrant_rr0 got=%h exp=%h", {bus.s_read[2], bus.c_cmdrdy, bus.s_ba[44 +: 22]}, {1'b1, 2'b01, ba0});
    end
  endtask

  task automatic test_random();
    logic [NS-1:0]    e_rd, e_wr, e_iba, e_q22;
    logic [NS*22-1:0] e_ba;
    logic [NS*32-1:0] e_lba;
    logic [NS*16-1:0] e_wc;
    logic [NC-1:0]    e_dr, e_cr, e_ws, e_nx, e_crc;
    int lo, dd, r;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      reset = ($urandom_range(0, 199) == 0);
      for (int c = 0; c < NC; c++) begin
        if ($urandom_range(0, 3) == 0) begin
          r = $urandom_range(0, 5);
          bus.c_read[c]  = (r == 1) || (r == 2);
          bus.c_write[c] = (r == 3) || (r == 4);
          bus.c_sdsel[c*SELW +: SELW] = 3'($urandom_range(0, 7));
        end
        bus.c_ba[c*22 +: 22]  = 22'($urandom());
        bus.c_lba[c*32 +: 32] = $urandom();
        bus.c_wc[c*16 +: 16]  = 16'($urandom());
      end
      bus.c_iba = NC'($urandom()); bus.c_q22 = NC'($urandom());
      for (int d = 0; d < NS; d++) begin
        if ($urandom_range(0, 7) == 0) bus.s_cmdrdy[d] = ~bus.s_cmdrdy[d];
      end
      bus.s_devrdy = NS'($urandom()); bus.s_word_st = NS'($urandom());
      bus.s_nxm = NS'($urandom()); bus.s_crcerr = NS'($urandom());
      #1;
      e_rd = '0; e_wr = '0; e_dr = '0; e_cr = '0; e_ws = '0; e_nx = '0; e_crc = '0;
      for (int d = 0; d < NS; d++) begin
        lo = last_owner[d];
        if (holder[d] >= 0) begin
          e_rd[d] = bus.c_read[holder[d]];
          e_wr[d] = bus.c_write[holder[d]];
          e_ws[holder[d]]  = e_ws[holder[d]]  | bus.s_word_st[d];
          e_nx[holder[d]]  = e_nx[holder[d]]  | bus.s_nxm[d];
          e_crc[holder[d]] = e_crc[holder[d]] | bus.s_crcerr[d];
        end
        e_ba[d*22 +: 22]  = bus.c_ba[lo*22 +: 22];
        e_lba[d*32 +: 32] = bus.c_lba[lo*32 +: 32];
        e_wc[d*16 +: 16]  = bus.c_wc[lo*16 +: 16];
        e_iba[d] = bus.c_iba[lo];
        e_q22[d] = bus.c_q22[lo];
      end
      for (int c = 0; c < NC; c++) begin
        dd = tb_dev(int'(bus.c_sdsel[c*SELW +: SELW]));
        e_dr[c] = bus.s_devrdy[dd];
        e_cr[c] = (holder[dd] < 0 || holder[dd] == c) ? bus.s_cmdrdy[dd] : 1'b0;
      end
      n_vec++;
      if ({bus.s_read, bus.s_write, bus.s_iba, bus.s_q22} !== {e_rd, e_wr, e_iba, e_q22}) begin
        n_err++; $display("FAIL rnd_s_ctl cyc=%0d got=%h exp=%h", cyc, {bus.s_read, bus.s_write, bus.s_iba, bus.s_q22}, {e_rd, e_wr, e_iba, e_q22});
      end
      n_vec++;
      if ({bus.s_ba, bus.s_lba, bus.s_wc} !== {e_ba, e_lba, e_wc}) begin
        n_err++; $display("FAIL rnd_s_data cyc=%0d got=%h exp=%h", cyc, {bus.s_ba, bus.s_lba, bus.s_wc}, {e_ba, e_lba, e_wc});
      end
      n_vec++;
      if ({bus.c_devrdy, bus.c_cmdrdy} !== {e_dr, e_cr}) begin
        n_err++; $display("FAIL rnd_c_rdy cyc=%0d got=%b exp=%b", cyc, {bus.c_devrdy, bus.c_cmdrdy}, {e_dr, e_cr});
      end
      n_vec++;
      if ({bus.c_word_st, bus.c_nxm, bus.c_crcerr} !== {e_ws, e_nx, e_crc}) begin
        n_err++; $display("FAIL rnd_c_status cyc=%0d got=%b exp=%b", cyc, {bus.c_word_st, bus.c_nxm, bus.c_crcerr}, {e_ws, e_nx, e_crc});
      end
      n_vec++;
      if (bus.c_timeout !== to_pulse_m) begin
        n_err++; $display("FAIL rnd_c_timeout cyc=%0d got=%b exp=%b", cyc, bus.c_timeout, to_pulse_m);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_single_read();
    test_contention();
    test_concurrent();
    test_sel_clamp();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sdctlxbar.md
# sdctlxbar

Parametrised crossbar connecting the control signals of NC disk controllers to NS storage devices. It supersedes the fixed two-controller, four-device single-owner mux. Each device has its own owner FSM, so transfers to different devices run concurrently. A per-device round-robin arbiter resolves contention, and a start watchdog frees a device that never accepts a command. It sits between the MSCP/RK/RL controller front-ends and the SD, RAM-disk and USB storage engines, in the bus clock domain.

## Interface
- NC, 2, number of disk controllers (2..8)
- NS, 4, number of storage devices (2..8); sdsel values >= NS select device NS-1
- SELW, 3, width of each controller's sdsel field
- START_TO, 1023, cycles allowed in ARM before the grant is revoked

Ports (controller c occupies slice c of each flattened vector; device d occupies slice d):
- clk  in  1  bus clock, 20 MHz; reset reset, synchronous, active-high; clock clk
- reset  in  1  synchronous, active-high
- c_sdsel  in  NC*SELW  device select per controller
- c_read, c_write  in  NC  command requests; the controller holds them until it sees its cmdrdy low
- c_ba  in  NC*22, c_lba  in  NC*32, c_wc  in  NC*16  transfer parameters
- c_iba, c_q22  in  NC  inhibit bus-address increment, 22-bit addressing
- c_devrdy, c_cmdrdy, c_word_st, c_nxm, c_crcerr  out  NC  status returned to each controller
- c_timeout  out  NC  one-cycle pulse when the watchdog revokes that controller's grant
- s_read, s_write  out  NS  gated commands to the devices
- s_ba  out  NS*22, s_lba  out  NS*32, s_wc  out  NS*16, s_iba, s_q22  out  NS  owner's parameters
- s_devrdy, s_cmdrdy, s_word_st, s_nxm, s_crcerr  in  NS  device status

## Operation
- Per-device state: IDLE, ARM, BUSY; owner[d] (log2 NC bits); rr[d] round-robin pointer.
- Request: controller c requests device d when (c_read[c] | c_write[c]) and dev(c_sdsel[c]) == d, and c owns no device.
- IDLE -> ARM: at least one request exists.
  - Grant goes to the first requester at or after rr[d], searching upward mod NC.
  - On grant: owner[d] <= winner, rr[d] <= winner+1 mod NC.
- ARM -> BUSY: s_cmdrdy[d] == 0 (device accepted the command).
- ARM -> IDLE: START_TO cycles elapse with s_cmdrdy[d] still 1; c_timeout[owner] pulses.
- BUSY -> IDLE: s_cmdrdy[d] == 1 (transfer done).
- Devices arbitrate independently; different devices may be granted to different controllers in the same cycle.
- Data path: s_ba/lba/wc/iba/q22[d] always show owner[d]'s inputs, including while IDLE (last owner; controller 0 after reset).
- s_read[d] = (state != IDLE) & c_read[owner[d]]; s_write likewise. Both are 0 in IDLE.
- c_word_st, c_nxm, c_crcerr[c] equal device d's signal when c owns d in ARM/BUSY; otherwise 0.
- c_devrdy[c] = s_devrdy[dev(c_sdsel[c])], ungated.
- c_cmdrdy[c]:
  - device's s_cmdrdy if c owns it, or if the device is IDLE;
  - 0 if another controller owns it (no faked ready).
- Watchdog counter: 10+ bits, saturating, cleared on entry to ARM.

## Timing
- Reset: all devices IDLE, owner = 0, rr = 0, counters 0. After the reset edge, every s_read, s_write, c_word_st, c_nxm, c_crcerr and c_timeout output is 0.
- Reset during a transfer drops s_read/s_write on the cycle after the reset edge. No pulse is generated.
- Grant latency: a request first sampled at edge N gives state ARM and s_read/s_write high from edge N+1. The data path is combinational from owner.
- State transitions and status gating take effect on the edge after the sampled condition.
- Owner release: IDLE is reached the edge after s_cmdrdy rises. Another pending requester can be granted the following edge, so the minimum device turnaround is 1 idle cycle.
- Simultaneous requests to the same device: one is granted, and the loser sees c_cmdrdy = 0 until release. Requests to different devices are each granted on the same edge.
- Timeout: c_timeout is high for exactly 1 cycle, on the cycle the device enters IDLE, START_TO cycles after ARM entry.

## Test plan
- Reset, then c0 read to sdsel=2 with s_cmdrdy[2] dropping 3 cycles later and rising 20 cycles later -> s_read[2] high from cycle +1, state BUSY, c_word_st[0] follows s_word_st[2], IDLE one edge after the rise, all other s_read = 0.
- c0 and c1 both write sdsel=1 in the same cycle, rr=0 -> c0 granted and c_cmdrdy[1] = 0 during the transfer; c1 granted one idle cycle after release. The next tie goes to c1.
- c0 to sdsel=0 and c1 to sdsel=3 simultaneously -> both granted on the same edge; s_ba[0] = c_ba[0] and s_ba[3] = c_ba[1].
- c1 sdsel=6 with NS=4 -> routed to device 3; c_devrdy[1] = s_devrdy[3].
- Device never drops cmdrdy, START_TO=15 -> c_timeout pulses exactly 15 cycles after grant, then the device returns to IDLE and s_read drops.
- Reset asserted mid-BUSY -> outputs clear the next edge; a new request afterwards is granted normally with rr = 0.
